// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
//   vend_state_e : FSM state encoding (also driven out on state_o)
//   Err*         : err_code values
//   SecW         : width of the seconds down-counter
//   coin_value() : coin code to credit units (0 for the invalid code)
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCredit = 3'd1,
        StPress  = 3'd2,
        StHeat   = 3'd3,
        StDisp   = 3'd4,
        StErr    = 3'd5,
        StRefund = 3'd6
    } vend_state_e;

    localparam logic [1:0] ErrNone   = 2'b00;
    localparam logic [1:0] ErrCredit = 2'b01;
    localparam logic [1:0] ErrSensor = 2'b10;
    localparam logic [1:0] ErrCoin   = 2'b11;

    localparam int unsigned SecW = 8;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] val;
        case (code)
            2'b00:   val = 3'd1;
            2'b01:   val = 3'd2;
            2'b10:   val = 3'd5;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_sec_timer.sv
// Phase timer: a tick prescaler (0..TICKS_PER_SEC-1) feeding a seconds down-counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : restart prescaler at 0 and load secs_i into the seconds counter
//   secs_i        : phase length in seconds
//   expire_o      : one-cycle pulse on the tick that ends the last loaded second
module vend_sec_timer
    import vend_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 700
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [SecW-1:0] secs_i,
    output logic            expire_o
);

    localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SecW-1:0] secs_q, secs_d;
    logic            tick;

    assign tick     = (cnt_q == CntW'(TICKS_PER_SEC - 1));
    assign expire_o = tick && (secs_q == SecW'(1));

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CntW'(1);
        secs_d = secs_q;
        if (tick && (secs_q != '0)) begin
            secs_d = secs_q - SecW'(1);
        end
        if (load_i) begin
            cnt_d  = '0;
            secs_d = secs_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            secs_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            secs_q <= secs_d;
        end
    end

endmodule

// File: rtl/vend_ctrl_gen2.sv
// Drink vending controller: coin credit, purchase, timed press/heat/dispense, error and refund.
// Optional feature macro: CHANGE_RETURN_EN (adds change_o/change_valid and cash-out refund).
//   clock, reset_n       : clock, asynchronous active-low reset
//   coin_code/coin_insert: coin pulse (00=1, 01=2, 10=5 units, 11=invalid)
//   enter, drink_sel     : purchase confirm pulse and channel select
//   price, sensor_err    : packed per-channel price table, per-channel fault level
//   state_o, credit_o    : FSM state code, current credit
//   coin_reject          : one-cycle pulse on a refused coin
//   pump_o/heater_o/dispense_o : actuators for PRESS/HEAT/DISP
//   rgb_red/green/blue   : status LED;  err_code : error cause while in ERR
module vend_ctrl_gen2
    import vend_pkg::*;
#(
    parameter int unsigned N_DRINKS      = 4,
    parameter int unsigned CREDIT_W      = 6,
    parameter int unsigned TICKS_PER_SEC = 700,
    parameter int unsigned T_IDLE_S      = 10,
    parameter int unsigned T_PRESS_S     = 2,
    parameter int unsigned T_HEAT_S      = 10,
    parameter int unsigned T_DISP_S      = 2,
    parameter int unsigned T_ERR_S       = 6
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [1:0]                   coin_code,
    input  logic                         coin_insert,
    input  logic                         enter,
    input  logic [$clog2(N_DRINKS)-1:0]  drink_sel,
    input  logic [N_DRINKS*CREDIT_W-1:0] price,
    input  logic [N_DRINKS-1:0]          sensor_err,
    output logic [2:0]                   state_o,
    output logic [CREDIT_W-1:0]          credit_o,
    output logic                         coin_reject,
    output logic                         pump_o,
    output logic                         heater_o,
    output logic                         dispense_o,
    output logic                         rgb_red,
    output logic                         rgb_green,
    output logic                         rgb_blue,
`ifdef CHANGE_RETURN_EN
    output logic [CREDIT_W-1:0]          change_o,
    output logic                         change_valid,
`endif
    output logic [1:0]                   err_code
);

    localparam logic [CREDIT_W-1:0] CreditMax = {CREDIT_W{1'b1}};

    vend_state_e                 state_q, state_d;
    logic [CREDIT_W-1:0]         credit_q, credit_d;
    logic [CREDIT_W-1:0]         paid_q, paid_d;  // price taken for the drink in progress
    logic [$clog2(N_DRINKS)-1:0] sel_q, sel_d;    // channel of the drink in progress
    logic [1:0]                  err_q, err_d;
    logic                        reject_q, reject_d;
    logic [2:0]                  led_q, led_d;    // {red, green, blue}

    logic                        load, coin_restart, expire;
    logic [SecW-1:0]             load_secs;
    logic [CREDIT_W:0]           coin_sum, restore_sum;
    logic [CREDIT_W-1:0]         sel_price;
    logic                        coin_ok, sel_valid;

    function automatic logic [SecW-1:0] phase_secs(input vend_state_e st);
        logic [SecW-1:0] s;
        case (st)
            StCredit: s = SecW'(T_IDLE_S);
            StPress:  s = SecW'(T_PRESS_S);
            StHeat:   s = SecW'(T_HEAT_S);
            StDisp:   s = SecW'(T_DISP_S);
            StErr:    s = SecW'(T_ERR_S);
            default:  s = '0;
        endcase
        return s;
    endfunction

    assign coin_sum    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_code));
    assign coin_ok     = (coin_code != 2'b11) && (coin_sum <= {1'b0, CreditMax});
    assign restore_sum = {1'b0, credit_q} + {1'b0, paid_q};
    assign sel_valid   = int'(drink_sel) < int'(N_DRINKS);
    assign sel_price   = price[drink_sel*CREDIT_W +: CREDIT_W];

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        paid_d       = paid_q;
        sel_d        = sel_q;
        err_d        = err_q;
        reject_d     = 1'b0;
        coin_restart = 1'b0;
        unique case (state_q)
            StIdle, StCredit: begin
                // A coin wins over a simultaneous enter.
                if (coin_insert) begin
                    if (coin_ok) begin
                        credit_d     = coin_sum[CREDIT_W-1:0];
                        state_d      = StCredit;
                        coin_restart = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                        err_d    = ErrCoin;
                        state_d  = StErr;
                    end
                end else if (enter) begin
                    if ((state_q == StIdle) || !sel_valid) begin
                        err_d   = ErrCredit;
                        state_d = StErr;
                    end else if (sensor_err[drink_sel]) begin
                        err_d   = ErrSensor;
                        state_d = StErr;
                    end else if (credit_q < sel_price) begin
                        err_d   = ErrCredit;
                        state_d = StErr;
                    end else begin
                        credit_d = credit_q - sel_price;
                        paid_d   = sel_price;
                        sel_d    = drink_sel;
                        state_d  = StPress;
                    end
                end else if ((state_q == StCredit) && expire) begin
                    state_d = StRefund;
                end
            end
            StPress, StHeat: begin
                reject_d = coin_insert;
                if (sensor_err[sel_q]) begin
                    err_d    = ErrSensor;
                    state_d  = StErr;
                    credit_d = restore_sum[CREDIT_W] ? CreditMax : restore_sum[CREDIT_W-1:0];
                end else if (expire) begin
                    state_d = (state_q == StPress) ? StHeat : StDisp;
                end
            end
            StDisp: begin
                reject_d = coin_insert;
                if (expire) begin
                    if (credit_q != '0) begin
`ifdef CHANGE_RETURN_EN
                        state_d = StRefund;
`else
                        state_d = StCredit;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StErr: begin
                reject_d = coin_insert;
                if (expire) begin
                    err_d   = ErrNone;
                    state_d = (credit_q != '0) ? StCredit : StIdle;
                end
            end
            StRefund: begin
                reject_d = coin_insert;
                state_d  = StIdle;
`ifdef CHANGE_RETURN_EN
                credit_d = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Any state change, or an accepted coin, restarts the phase timer from tick 0.
    assign load      = (state_d != state_q) || coin_restart;
    assign load_secs = phase_secs(state_d);

    vend_sec_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_timer (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .load_i  (load),
        .secs_i  (load_secs),
        .expire_o(expire)
    );

    always_comb begin
        led_d = 3'b000;
        unique case (state_d)
            StIdle:                  led_d = 3'b001;
            StCredit:                led_d = 3'b011;
            StPress, StHeat, StDisp: led_d = 3'b010;
            StErr:                   led_d = 3'b100;
            StRefund:                led_d = 3'b110;
            default:                 led_d = 3'b000;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            credit_q <= '0;
            paid_q   <= '0;
            sel_q    <= '0;
            err_q    <= ErrNone;
            reject_q <= 1'b0;
            led_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            paid_q   <= paid_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            reject_q <= reject_d;
            led_q    <= led_d;
        end
    end

    // Actuators decode the state register directly so reset drops them without a clock.
    assign state_o     = state_q;
    assign credit_o    = credit_q;
    assign coin_reject = reject_q;
    assign err_code    = err_q;
    assign pump_o      = (state_q == StPress);
    assign heater_o    = (state_q == StHeat);
    assign dispense_o  = (state_q == StDisp);
    assign {rgb_red, rgb_green, rgb_blue} = led_q;

`ifdef CHANGE_RETURN_EN
    assign change_valid = (state_q == StRefund);
    assign change_o     = change_valid ? credit_q : '0;
`endif

endmodule
